// File: rtl/program_memory_loader.sv
// Boot loader and 32x8 program/data memory for the byte computer core.
// Optional feature macro: DUMP_EN (streams memory out after the core halts).
//
// state | meaning
// IDLE  | one cycle after reset, then load
// LOAD  | accept program bytes into mem[load_ptr]
// RUN   | core owns the memory bus, cpu_start high
// DONE  | core halted, memory frozen, optional dump
module program_memory_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              cpu_start,
  input  logic              cpu_halt,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [1:0]        state,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            cur_state, next_state;
  logic [ADDR_W-1:0] load_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              load_fire;

  assign load_fire = (cur_state == LOAD) && load_valid;
  assign state     = cur_state;

  always_ff @(posedge clk) begin
    if (rst) cur_state <= IDLE;
    else     cur_state <= next_state;
  end

  always_comb begin
    next_state = cur_state;
    load_ready = 1'b0;
    cpu_start  = 1'b0;
    case (cur_state)
      IDLE: next_state = LOAD;
      LOAD: begin
        load_ready = 1'b1;
        if (load_fire && (load_last || load_ptr == LAST_ADDR)) next_state = RUN;
      end
      RUN: begin
        cpu_start = 1'b1;
        if (cpu_halt) next_state = DONE;
      end
      DONE: next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Read-first port: cpu_rdata samples the old word even when written this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      load_ptr  <= '0;
      cpu_rdata <= '0;
    end else begin
      case (cur_state)
        LOAD: begin
          if (load_valid) begin
            mem[load_ptr] <= load_data;
            if (load_ptr != LAST_ADDR) load_ptr <= load_ptr + 1'b1;
          end
        end
        RUN: begin
          cpu_rdata <= mem[cpu_addr];
          if (cpu_we) mem[cpu_addr] <= cpu_wdata;
        end
        default: ;
      endcase
    end
  end

`ifdef DUMP_EN
  logic [ADDR_W-1:0] dump_ptr;
  logic              dump_done;

  // Memory is frozen in DONE, so reading it combinationally keeps dump_data stable.
  assign dump_valid = (cur_state == DONE) && !dump_done;
  assign dump_data  = dump_valid ? mem[dump_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      dump_ptr  <= '0;
      dump_done <= 1'b0;
    end else if (dump_valid && dump_ready) begin
      if (dump_ptr == LAST_ADDR) dump_done <= 1'b1;
      else                       dump_ptr  <= dump_ptr + 1'b1;
    end
  end
`else
  assign dump_valid = 1'b0;
  assign dump_data  = {DATA_W{1'b0}} & {DATA_W{dump_ready}};
`endif

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed self-checking bench for program_memory_loader (build with +define+DUMP_EN for dump checks).
module tb_program_memory_loader;

  logic       clk = 1'b0;
  logic       rst, load_valid, load_last, cpu_halt, cpu_we, dump_ready;
  logic       load_ready, cpu_start, dump_valid;
  logic [7:0] load_data, cpu_wdata, cpu_rdata, dump_data;
  logic [4:0] cpu_addr;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  program_memory_loader dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .cpu_start(cpu_start), .cpu_halt(cpu_halt), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .state(state),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  logic [7:0] exp_mem [32];
  int         accepts, beats, cyc;
  logic       stalled;
  logic [7:0] held;

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = 8'h00;
    cpu_halt = 1'b0; cpu_we = 1'b0; cpu_addr = 5'd0; cpu_wdata = 8'h00; dump_ready = 1'b0;
    tick(); tick();
    check("rst_state", state, 2'd0);
    check("rst_start", cpu_start, 1'b0);
    check("rst_ready", load_ready, 1'b0);
    check("rst_rdata", cpu_rdata, 8'h00);
    check("rst_dump_valid", dump_valid, 1'b0);
    check("rst_dump_data", dump_data, 8'h00);
    rst = 1'b0;
    tick();
    check("idle_to_load", state, 2'd1);
    check("load_ready", load_ready, 1'b1);

    // 1: three-byte program
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    check("still_load", state, 2'd1);
    send(8'h33, 1'b1);
    check("t1_run", state, 2'd2);
    check("t1_start", cpu_start, 1'b1);
    check("t1_ready_low", load_ready, 1'b0);
    cpu_addr = 5'd2; tick();
    check("t1_rd2", cpu_rdata, 8'h33);
    cpu_addr = 5'd3; tick();
    check("t1_rd3", cpu_rdata, 8'h00);
    cpu_addr = 5'd0; tick();
    check("t1_rd0", cpu_rdata, 8'h11);

    // 2: write then read, read-first collision
    cpu_addr = 5'd5; cpu_we = 1'b1; cpu_wdata = 8'hA5; tick();
    check("t2_read_first", cpu_rdata, 8'h00);
    cpu_we = 1'b0; tick();
    check("t2_rd5", cpu_rdata, 8'hA5);

    // 4: halt with a same-cycle write, then frozen memory
    cpu_halt = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd7; cpu_wdata = 8'h5A; tick();
    cpu_halt = 1'b0;
    check("t4_done", state, 2'd3);
    check("t4_start_low", cpu_start, 1'b0);
    check("t4_halt_write", dut.mem[7], 8'h5A);
    cpu_wdata = 8'hFF; tick();
    cpu_we = 1'b0;
    check("t4_frozen", dut.mem[7], 8'h5A);
    check("t4_rdata_hold", cpu_rdata, 8'h00);
    check("t4_stays_done", state, 2'd3);

`ifdef DUMP_EN
    // 6: dump with a pseudo-random 50% ready pattern
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h00;
    exp_mem[0] = 8'h11; exp_mem[1] = 8'h22; exp_mem[2] = 8'h33;
    exp_mem[5] = 8'hA5; exp_mem[7] = 8'h5A;
    beats = 0; cyc = 0; stalled = 1'b0; held = 8'h00;
    while (beats < 32 && cyc < 400) begin
      dump_ready = $urandom_range(0, 1) == 1;
      #2;
      if (dump_valid) begin
        if (stalled) check("t6_stable", dump_data, held);
        if (dump_ready) begin
          check("t6_beat", dump_data, exp_mem[beats]);
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = dump_data;
        end
      end
      tick();
      cyc++;
    end
    dump_ready = 1'b1;
    check("t6_beats", beats, 32);
    tick(); tick();
    check("t6_valid_end", dump_valid, 1'b0);
`else
    dump_ready = 1'b1;
    tick();
    check("dump_valid_off", dump_valid, 1'b0);
    check("dump_data_off", dump_data, 8'h00);
`endif

    // 5: reset mid-load discards partial load
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_idle_a", state, 2'd0);
    tick();
    check("t5_load_a", state, 2'd1);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_idle_b", state, 2'd0);
    tick();
    check("t5_load_b", state, 2'd1);
    send(8'h00, 1'b1);
    check("t5_run", state, 2'd2);
    cpu_addr = 5'd0; tick();
    check("t5_rd0", cpu_rdata, 8'h00);
    cpu_addr = 5'd1; tick();
    check("t5_rd1", cpu_rdata, 8'h00);

    // 3: overfull stream stops at 32 bytes
    rst = 1'b1; tick(); rst = 1'b0; tick();
    accepts = 0;
    for (int i = 0; i < 40; i++) begin
      load_valid = 1'b1;
      load_data  = 8'h80 + 8'(i);
      if (load_ready) accepts++;
      tick();
      if (i == 31) check("t3_ready_low", load_ready, 1'b0);
    end
    load_valid = 1'b0;
    check("t3_accepts", accepts, 32);
    check("t3_run", state, 2'd2);
    cpu_addr = 5'd31; tick();
    check("t3_rd31", cpu_rdata, 8'h9F);
    cpu_addr = 5'd0; tick();
    check("t3_rd0", cpu_rdata, 8'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
